// File: rtl/frame_pkg.sv
// Shared definitions for the UART frame decoder: framing byte values, the
// decoder state enum, the error-code enum, the unstuffed-byte struct and a
// helper that sizes the channel field.
package frame_pkg;

    localparam logic [7:0] FLAG_BYTE = 8'h7E;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [2:0] {
        ST_HUNT, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM, ST_END
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_ADDR  = 3'd1,
        ERR_LEN   = 3'd2,
        ERR_FRAME = 3'd3,
        ERR_CSUM  = 3'd4
    } err_code_e;

    // Byte after escape removal; flag marks an unescaped 0x7E.
    typedef struct packed {
        logic [7:0] data;
        logic       flag;
    } ubyte_t;

    // Channel field width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-in / word-out bus of the UART frame decoder.
//   rx_*      : byte stream into the decoder (valid/ready)
//   m_*       : decoded payload words out of the decoder (valid/ready)
//   frame_ok, err, err_code : frame status
// master = byte source / word consumer, slave = decoder.
interface uart_frame_decoder_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32
);
    localparam int CH_W = frame_pkg::ch_w(NUM_CH);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] m_data;
    logic [CH_W-1:0]   m_ch;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic              frame_ok;
    logic              err;
    logic [2:0]        err_code;

    modport master (
        output rx_data, rx_valid, m_ready,
        input  rx_ready, m_data, m_ch, m_valid, m_last, frame_ok, err, err_code
    );

    modport slave (
        input  rx_data, rx_valid, m_ready,
        output rx_ready, m_data, m_ch, m_valid, m_last, frame_ok, err, err_code
    );
endinterface

// File: rtl/frame_unstuff.sv
// Escape removal in front of the frame parser. A 0x7D is swallowed and the
// following byte is XORed with 0x20; an unescaped 0x7E is tagged as a flag.
// Ports: sysclk, rstn; in_* raw byte stream; out_* unstuffed byte stream.
module frame_unstuff
    import frame_pkg::*;
(
    input  logic       sysclk,
    input  logic       rstn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output ubyte_t     out_byte,
    output logic       out_valid,
    input  logic       out_ready
);
    logic esc;
    logic is_esc;

    // Escape bytes are also held off while downstream stalls, so the input
    // ready seen by the sender depends only on the consumer.
    assign in_ready      = out_ready;
    assign is_esc        = !esc && (in_data == ESC_BYTE);
    assign out_valid     = in_valid && !is_esc;
    assign out_byte.data = esc ? (in_data ^ ESC_XOR) : in_data;
    assign out_byte.flag = !esc && (in_data == FLAG_BYTE);

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn)                    esc <= 1'b0;
        else if (in_valid && in_ready) esc <= is_esc;
    end
endmodule

// File: rtl/uart_frame_decoder.sv
// UART frame decoder: FLAG, ADDR, LEN, payload[LEN], [CSUM], FLAG.
// Payload bytes are packed big-endian into DATA_W words and tagged with the
// channel from ADDR. The final word is held until the closing flag arrives.
// Ports: sysclk, rstn (async, active low), bus (uart_frame_decoder_if.slave).
// Build option: define FRAME_CHECKSUM_EN to expect a CSUM byte after the
// payload (8-bit sum of ADDR+LEN+payload+CSUM must be zero).
module uart_frame_decoder
    import frame_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 255
) (
    input  logic sysclk,
    input  logic rstn,
    uart_frame_decoder_if.slave bus
);
    localparam int BPW  = DATA_W / 8;
    localparam int CH_W = ch_w(NUM_CH);
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
`ifdef FRAME_CHECKSUM_EN
    localparam state_e AFTER_DATA = ST_CSUM;
`else
    localparam state_e AFTER_DATA = ST_END;
`endif

    state_e            state, state_n;
    ubyte_t            ub;
    logic              ub_valid, ub_ready, take, run, stall;
    logic [CH_W-1:0]   ch, m_ch_q;
    logic [7:0]        len, cnt;
    logic [BI_W-1:0]   bi;
    logic [DATA_W-1:0] acc, word_n, m_data_q;
    logic              m_valid_q, m_last_q, err_q;
    err_code_e         code_n, code_q;
    logic              set_err, latch_addr, start_data, store_byte;
    logic              emit_word, emit_last;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    // run holds the input off until the first clock after reset release.
    assign stall    = m_valid_q && !bus.m_ready;
    assign ub_ready = run && !stall;
    assign take     = ub_valid && ub_ready;

    frame_unstuff u_unstuff (
        .sysclk   (sysclk),
        .rstn     (rstn),
        .in_data  (bus.rx_data),
        .in_valid (bus.rx_valid),
        .in_ready (bus.rx_ready),
        .out_byte (ub),
        .out_valid(ub_valid),
        .out_ready(ub_ready)
    );

    assign bus.m_data   = m_data_q;
    assign bus.m_ch     = m_ch_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_last   = m_last_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.frame_ok = m_valid_q && bus.m_ready && m_last_q;

    // Current word with the incoming byte dropped into its big-endian slot.
    always_comb begin
        word_n = acc;
        word_n[(BPW-1-int'(bi))*8 +: 8] = ub.data;
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) state <= ST_HUNT;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        set_err    = 1'b0;
        code_n     = ERR_NONE;
        latch_addr = 1'b0;
        start_data = 1'b0;
        store_byte = 1'b0;
        emit_word  = 1'b0;
        emit_last  = 1'b0;
        if (take) begin
            unique case (state)
                ST_HUNT: if (ub.flag) state_n = ST_ADDR;
                ST_ADDR: if (!ub.flag) begin       // repeated flags are idle fill
                    if (int'(ub.data) >= NUM_CH) begin
                        set_err = 1'b1; code_n = ERR_ADDR; state_n = ST_HUNT;
                    end else begin
                        latch_addr = 1'b1; state_n = ST_LEN;
                    end
                end
                ST_LEN: if (ub.flag) begin
                    set_err = 1'b1; code_n = ERR_FRAME; state_n = ST_ADDR;
                end else if (ub.data == 8'd0 || int'(ub.data) > MAX_LEN) begin
                    set_err = 1'b1; code_n = ERR_LEN; state_n = ST_HUNT;
                end else begin
                    start_data = 1'b1; state_n = ST_DATA;
                end
                // A flag inside the payload aborts and opens the next frame.
                ST_DATA: if (ub.flag) begin
                    set_err = 1'b1; code_n = ERR_FRAME; state_n = ST_ADDR;
                end else begin
                    store_byte = 1'b1;
                    if (cnt + 8'd1 == len)           state_n   = AFTER_DATA;
                    else if (int'(bi) == BPW - 1)    emit_word = 1'b1;
                end
`ifdef FRAME_CHECKSUM_EN
                ST_CSUM: if (ub.flag) begin
                    set_err = 1'b1; code_n = ERR_FRAME; state_n = ST_ADDR;
                end else if (sum + ub.data != 8'd0) begin
                    set_err = 1'b1; code_n = ERR_CSUM; state_n = ST_HUNT;
                end else begin
                    state_n = ST_END;
                end
`endif
                ST_END: if (ub.flag) begin
                    emit_last = 1'b1; state_n = ST_ADDR;   // closing flag may open the next frame
                end else begin
                    set_err = 1'b1; code_n = ERR_FRAME; state_n = ST_HUNT;
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            run       <= 1'b0;
            ch        <= '0;
            len       <= '0;
            cnt       <= '0;
            bi        <= '0;
            acc       <= '0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
`ifdef FRAME_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            run   <= 1'b1;
            err_q <= set_err;
            if (set_err) code_q <= code_n;
            if (latch_addr) ch <= ub.data[CH_W-1:0];
            if (start_data) begin
                len <= ub.data;
                cnt <= '0;
                bi  <= '0;
                acc <= '0;
            end
            // After the last payload byte acc keeps the padded final word.
            if (store_byte) begin
                cnt <= cnt + 8'd1;
                bi  <= (int'(bi) == BPW - 1) ? '0 : bi + BI_W'(1);
                acc <= emit_word ? '0 : word_n;
            end
`ifdef FRAME_CHECKSUM_EN
            if (latch_addr)                    sum <= ub.data;
            else if (start_data || store_byte) sum <= sum + ub.data;
`endif
            // Bytes are only taken when the output slot is free or draining.
            if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
            if (emit_word || emit_last) begin
                m_valid_q <= 1'b1;
                m_data_q  <= emit_last ? acc : word_n;
                m_last_q  <= emit_last;
                m_ch_q    <= ch;
            end
        end
    end
endmodule
